// File: rtl/ava_scan_controller.sv
// Raster scan coordinate generator with a small register file.
// Issues (x, y) fetch coordinates across a frame, stalls on a full pixel FIFO,
// counts frames and raises a vertical-blank interrupt at each frame end.
module ava_scan_controller #(
  parameter int unsigned X_MAX   = 639,
  parameter int unsigned Y_MAX   = 479,
  parameter int unsigned COORD_W = 10,
  parameter int unsigned FCNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fifo_full,
  input  logic               reg_we,
  input  logic [1:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic [1:0]         vga_mode,
  output logic [COORD_W-1:0] coord_x,
  output logic [COORD_W-1:0] coord_y,
  output logic               coord_valid,
  output logic               frame_start,
  output logic               vblank_irq
);

  localparam logic [COORD_W-1:0] XLast = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] YLast = COORD_W'(Y_MAX);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StFrameEnd
  } state_e;

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  x_q, x_d;
  logic [COORD_W-1:0]  y_q, y_d;
  logic [1:0]          vga_mode_q, vga_mode_d;
  logic [FCNT_W-1:0]   frame_count_q, frame_count_d;
  logic                irq_pending_q, irq_pending_d;
  logic                enable_q, enable_d;
  logic                irq_en_q, irq_en_d;
  logic [1:0]          mode_next_q, mode_next_d;

  logic irq_set;
  logic ctrl_wr;
  logic status_clr;
  logic busy;

  // Upper write-data bits have no register behind them.
  logic unused_wdata;
  assign unused_wdata = ^reg_wdata[31:4];

  assign ctrl_wr    = reg_we && (reg_addr == 2'd0);
  assign status_clr = reg_we && (reg_addr == 2'd1) && reg_wdata[0];
  assign busy       = (state_q != StIdle);

  // Scan FSM: next state, coordinate advance, frame-end bookkeeping.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    vga_mode_d    = vga_mode_q;
    frame_count_d = frame_count_q;
    irq_set       = 1'b0;
    coord_valid   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable_q) begin
          state_d    = StScan;
          x_d        = '0;
          y_d        = '0;
          vga_mode_d = mode_next_q;
        end
      end
      StScan: begin
        coord_valid = ~fifo_full;
        if (coord_valid) begin
          if (x_q != XLast) begin
            x_d = x_q + COORD_W'(1);
          end else begin
            x_d = '0;
            if (y_q != YLast) begin
              y_d = y_q + COORD_W'(1);
            end else begin
              y_d     = '0;
              state_d = StFrameEnd;
            end
          end
        end
      end
      StFrameEnd: begin
        frame_count_d = frame_count_q + FCNT_W'(1);
        irq_set       = 1'b1;
        vga_mode_d    = mode_next_q;
        // Enable is sampled only here, so a mid-frame clear lets the frame finish.
        state_d       = enable_q ? StScan : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Register file next state; a frame-end set beats a same-cycle W1C clear.
  always_comb begin
    enable_d      = enable_q;
    irq_en_d      = irq_en_q;
    mode_next_d   = mode_next_q;
    irq_pending_d = irq_pending_q;
    if (ctrl_wr) begin
      enable_d    = reg_wdata[0];
      irq_en_d    = reg_wdata[1];
      mode_next_d = reg_wdata[3:2];
    end
    if (irq_set) begin
      irq_pending_d = 1'b1;
    end else if (status_clr) begin
      irq_pending_d = 1'b0;
    end
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      x_q           <= '0;
      y_q           <= '0;
      vga_mode_q    <= '0;
      frame_count_q <= '0;
      irq_pending_q <= 1'b0;
      enable_q      <= 1'b0;
      irq_en_q      <= 1'b0;
      mode_next_q   <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      vga_mode_q    <= vga_mode_d;
      frame_count_q <= frame_count_d;
      irq_pending_q <= irq_pending_d;
      enable_q      <= enable_d;
      irq_en_q      <= irq_en_d;
      mode_next_q   <= mode_next_d;
    end
  end

  // Combinational register read mux.
  always_comb begin
    reg_rdata = '0;
    unique case (reg_addr)
      2'd0:    reg_rdata = {28'd0, mode_next_q, irq_en_q, enable_q};
      2'd1:    reg_rdata = {30'd0, busy, irq_pending_q};
      2'd2:    reg_rdata = 32'(frame_count_q);
      default: reg_rdata = '0;
    endcase
  end

  assign coord_x     = x_q;
  assign coord_y     = y_q;
  assign vga_mode    = vga_mode_q;
  assign frame_start = coord_valid && (x_q == '0) && (y_q == '0);
  assign vblank_irq  = irq_pending_q && irq_en_q;

endmodule

// File: tb/tb_ava_scan_controller.sv
// Bench for ava_scan_controller on a 4x2 frame with a 2-bit frame counter.
// A frame-position model is checked every cycle; directed steps pin key values.
module tb_ava_scan_controller;

  localparam int X_MAX   = 3;
  localparam int Y_MAX   = 1;
  localparam int COORD_W = 2;
  localparam int FCNT_W  = 2;
  localparam int NPIX    = (X_MAX + 1) * (Y_MAX + 1);

  logic               clk = 1'b0;
  logic               reset;
  logic               fifo_full;
  logic               reg_we;
  logic [1:0]         reg_addr;
  logic [31:0]        reg_wdata;
  logic [31:0]        reg_rdata;
  logic [1:0]         vga_mode;
  logic [COORD_W-1:0] coord_x;
  logic [COORD_W-1:0] coord_y;
  logic               coord_valid;
  logic               frame_start;
  logic               vblank_irq;

  int checks = 0;
  int fails  = 0;

  // Model: phase 0 = idle, 1 = scanning, 2 = frame-end gap; pos = linear pixel index.
  int m_run = 0, m_pos = 0, m_en = 0, m_irqen = 0, m_next = 0;
  int m_mode = 0, m_pend = 0, m_fc = 0;

  ava_scan_controller #(
    .X_MAX  (X_MAX),
    .Y_MAX  (Y_MAX),
    .COORD_W(COORD_W),
    .FCNT_W (FCNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_full  (fifo_full),
    .reg_we     (reg_we),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .vga_mode   (vga_mode),
    .coord_x    (coord_x),
    .coord_y    (coord_y),
    .coord_valid(coord_valid),
    .frame_start(frame_start),
    .vblank_irq (vblank_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    @(posedge clk); #1;
    reg_we = 1'b0;
  endtask

  // Behavioural model advances on each rising edge from the values seen there.
  initial begin : model
    int o_run, o_en, o_next;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_run = 0; m_pos = 0; m_en = 0; m_irqen = 0; m_next = 0;
        m_mode = 0; m_pend = 0; m_fc = 0;
      end else begin
        o_run = m_run; o_en = m_en; o_next = m_next;
        if (o_run == 0) begin
          if (o_en != 0) begin m_run = 1; m_pos = 0; m_mode = o_next; end
        end else if (o_run == 1) begin
          if (!fifo_full) begin
            if (m_pos == NPIX - 1) begin m_pos = 0; m_run = 2; end
            else m_pos = m_pos + 1;
          end
        end else begin
          m_fc   = (m_fc + 1) % (1 << FCNT_W);
          m_pend = 1;
          m_mode = o_next;
          m_run  = (o_en != 0) ? 1 : 0;
        end
        if (reg_we) begin
          if (reg_addr == 2'd0) begin
            m_en    = int'(reg_wdata[0]);
            m_irqen = int'(reg_wdata[1]);
            m_next  = int'(reg_wdata[3:2]);
          end else if (reg_addr == 2'd1 && reg_wdata[0] && o_run != 2) begin
            m_pend = 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison on the falling edge.
  initial begin : compare
    logic        e_valid;
    logic [31:0] e_rd;
    forever begin
      @(negedge clk);
      e_valid = (m_run == 1) && !fifo_full;
      case (reg_addr)
        2'd0:    e_rd = 32'(m_next * 4 + m_irqen * 2 + m_en);
        2'd1:    e_rd = 32'(((m_run != 0) ? 2 : 0) + m_pend);
        2'd2:    e_rd = 32'(m_fc);
        default: e_rd = 32'd0;
      endcase
      chk("model coord_valid", 32'(coord_valid), 32'(e_valid));
      chk("model coord_x", 32'(coord_x), 32'(m_pos % (X_MAX + 1)));
      chk("model coord_y", 32'(coord_y), 32'(m_pos / (X_MAX + 1)));
      chk("model frame_start", 32'(frame_start), 32'(e_valid && m_pos == 0));
      chk("model vga_mode", 32'(vga_mode), 32'(m_mode));
      chk("model vblank_irq", 32'(vblank_irq), 32'(m_pend != 0 && m_irqen != 0));
      chk("model reg_rdata", reg_rdata, e_rd);
    end
  end

  initial begin : stim
    int n, cnt, found;
    reset = 1'b1; fifo_full = 1'b0; reg_we = 1'b0; reg_addr = 2'd0; reg_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset coord_valid", 32'(coord_valid), 32'd0);
    chk("reset vga_mode", 32'(vga_mode), 32'd0);
    chk("reset ctrl", reg_rdata, 32'd0);

    // Full frame with no stalls.
    wr(2'd0, 32'h1);
    @(negedge clk);
    chk("idle before scan", 32'(coord_valid), 32'd0);
    for (int i = 0; i < NPIX; i++) begin
      @(posedge clk); @(negedge clk);
      chk("seq valid", 32'(coord_valid), 32'd1);
      chk("seq x", 32'(coord_x), 32'(i % 4));
      chk("seq y", 32'(coord_y), 32'(i / 4));
      chk("seq frame_start", 32'(frame_start), 32'(i == 0));
    end
    @(posedge clk); @(negedge clk);
    chk("gap cycle", 32'(coord_valid), 32'd0);
    @(posedge clk); #1 reg_addr = 2'd2;
    @(negedge clk);
    chk("frame_count 1", reg_rdata, 32'd1);
    chk("second frame_start", 32'(frame_start), 32'd1);

    // Stall for three cycles at (2,0).
    @(posedge clk); @(posedge clk); #1 fifo_full = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("stall valid", 32'(coord_valid), 32'd0);
      chk("stall x", 32'(coord_x), 32'd2);
      chk("stall y", 32'(coord_y), 32'd0);
      @(posedge clk);
    end
    #1 fifo_full = 1'b0;
    @(negedge clk);
    chk("resume valid", 32'(coord_valid), 32'd1);
    chk("resume x", 32'(coord_x), 32'd2);

    // mode_next = 2 written mid-frame.
    wr(2'd0, 32'h9);
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!coord_valid) break;
      @(posedge clk);
    end
    chk("wait frame end 1", 32'(n < 20), 32'd1);
    chk("mode held in frame_end", 32'(vga_mode), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("mode after frame_end", 32'(vga_mode), 32'd2);
    chk("ctrl readback", reg_rdata, 32'h9);

    // Interrupt enable, W1C clear, and set-wins collision.
    wr(2'd0, 32'hB);
    @(negedge clk);
    chk("irq on enable", 32'(vblank_irq), 32'd1);
    wr(2'd1, 32'h1);
    @(negedge clk);
    chk("irq cleared", 32'(vblank_irq), 32'd0);
    chk("status after clear", reg_rdata, 32'h2);
    repeat (4) @(posedge clk);
    #1 reg_we = 1'b1; reg_addr = 2'd1; reg_wdata = 32'h1;
    @(negedge clk);
    chk("in frame_end", 32'(coord_valid), 32'd0);
    @(posedge clk); #1 reg_we = 1'b0;
    @(negedge clk);
    chk("set wins status", reg_rdata, 32'h3);
    chk("set wins irq", 32'(vblank_irq), 32'd1);
    @(posedge clk); #1 reg_addr = 2'd2;
    @(negedge clk);
    chk("frame_count 3", reg_rdata, 32'd3);

    // Clear enable during (1,0): frame completes, then idle; count wraps.
    #1 reg_we = 1'b1; reg_addr = 2'd0; reg_wdata = 32'h0;
    @(posedge clk); #1 reg_we = 1'b0; reg_addr = 2'd1;
    cnt = 0;
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (!reg_rdata[1]) break;
      if (coord_valid) cnt++;
      @(posedge clk);
    end
    chk("wait idle", 32'(n < 30), 32'd1);
    chk("issues after disable", 32'(cnt), 32'd6);
    chk("idle valid", 32'(coord_valid), 32'd0);
    @(posedge clk); #1 reg_addr = 2'd2;
    @(negedge clk);
    chk("frame_count wrap", reg_rdata, 32'd0);
    chk("mode back to 0", 32'(vga_mode), 32'd0);

    // Address 3 reads zero and ignores writes.
    wr(2'd3, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("addr3 read", reg_rdata, 32'd0);
    #1 reg_addr = 2'd0;
    @(negedge clk);
    chk("ctrl untouched", reg_rdata, 32'd0);

    // Reset at (2,1) of the second frame.
    wr(2'd0, 32'h1);
    #1 reg_addr = 2'd2;
    found = 0;
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (coord_valid && coord_x == 2'd2 && coord_y == 2'd1) begin
        found++;
        if (found == 2) break;
      end
      @(posedge clk);
    end
    chk("reached (2,1) twice", 32'(found), 32'd2);
    chk("frame_count before reset", reg_rdata, 32'd1);
    #1 reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("reset mid valid", 32'(coord_valid), 32'd0);
    chk("reset mid x", 32'(coord_x), 32'd0);
    chk("reset mid y", 32'(coord_y), 32'd0);
    chk("reset mid frame_count", reg_rdata, 32'd0);
    #1 reg_addr = 2'd1;
    @(negedge clk);
    chk("reset mid status", reg_rdata, 32'd0);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("stays idle", 32'(coord_valid), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/ava_scan_controller.md
AVA_SCAN_CONTROLLER -- requirements
Module: ava_scan_controller

Interface
REQ-001 Parameter X_MAX, default 639, last x coordinate of a frame.
REQ-002 Parameter Y_MAX, default 479, last y coordinate of a frame.
REQ-003 Parameter COORD_W, default 10, coordinate width; SHALL satisfy 2^COORD_W > max(X_MAX, Y_MAX).
REQ-004 Parameter FCNT_W, default 16, frame counter width.
REQ-005 Clock clk; reset reset, synchronous, active-high.
REQ-006 clk  input  1  system clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 fifo_full  input  1  downstream pixel FIFO full; stalls coordinate advance.
REQ-009 reg_we  input  1  register write strobe.
REQ-010 reg_addr  input  2  register address.
REQ-011 reg_wdata  input  32  register write data.
REQ-012 reg_rdata  output  32  register read data, combinational from reg_addr.
REQ-013 vga_mode  output  2  active mode (0 = VGA_DIRECT_MODE), frame-stable.
REQ-014 coord_x / coord_y  output  COORD_W each  current fetch coordinate.
REQ-015 coord_valid  output  1  coordinate issued this cycle.
REQ-016 frame_start  output  1  one-cycle pulse with the (0,0) issue.
REQ-017 vblank_irq  output  1  level interrupt, = irq_pending AND irq_en.

Function
REQ-018 Register map SHALL be: addr0 CTRL (bit0 enable, bit1 irq_en, bits3:2 mode_next; R/W); addr1 STATUS (bit0 irq_pending, write-1-to-clear; bit1 busy, read-only); addr2 FRAME_COUNT (read-only, zero-extended); addr3 reads 0, writes ignored; unused bits read 0.
REQ-019 FSM SHALL have states IDLE, SCAN, FRAME_END; busy = (state != IDLE).
REQ-020 IDLE: coord_valid=0; when CTRL.enable=1, next cycle enter SCAN with coords (0,0) and vga_mode <= mode_next.
REQ-021 SCAN: coord_valid = NOT fifo_full; coords hold while fifo_full=1.
REQ-022 On an issue with x<X_MAX: x <= x+1.
REQ-023 On an issue with x==X_MAX, y<Y_MAX: x <= 0, y <= y+1.
REQ-024 On an issue with x==X_MAX, y==Y_MAX: x <= 0, y <= 0, enter FRAME_END.
REQ-025 FRAME_END (exactly one cycle): coord_valid=0; frame_count <= frame_count+1 (wraps modulo 2^FCNT_W); irq_pending <= 1; vga_mode <= mode_next; then SCAN if enable=1, else IDLE.
REQ-026 Clearing enable mid-frame SHALL NOT abort; the frame completes, then IDLE.
REQ-027 mode_next writes mid-frame SHALL take effect only at the next FRAME_END or IDLE->SCAN transition.
REQ-028 frame_start = coord_valid AND x==0 AND y==0.
REQ-029 Simultaneous irq set (FRAME_END) and STATUS W1C clear in the same cycle: set wins, irq_pending=1.
REQ-030 irq_pending SHALL set regardless of irq_en; enabling irq_en later asserts vblank_irq immediately.
REQ-031 Register writes SHALL take effect the cycle after reg_we; reads reflect current register state.

Reset
REQ-032 On reset: state IDLE, coords (0,0), coord_valid=0, frame_start=0, vga_mode=0, CTRL=0, irq_pending=0, frame_count=0, vblank_irq=0.
REQ-033 Reset asserted mid-frame SHALL apply REQ-032 on the next clk edge, with no FRAME_END and no irq.

Verification (X_MAX=3, Y_MAX=1, FCNT_W=2)
REQ-034 Write CTRL=1, fifo_full=0 -> coords (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1) on 8 consecutive cycles, one gap cycle, frame_count=1, irq_pending=1, frame_start on each (0,0).
REQ-035 fifo_full=1 for 3 cycles at (2,0) -> coord_valid=0 and coords held at (2,0) for 3 cycles, then resume at (2,0).
REQ-036 Write CTRL mode_next=2 mid-frame -> vga_mode stays 0 until the FRAME_END cycle, then 2.
REQ-037 irq_en=1, frame end -> vblank_irq=1; write STATUS=1 in the next FRAME_END cycle -> irq_pending remains 1; write STATUS=1 elsewhere -> 0 next cycle.
REQ-038 Clear enable at (1,0) -> frame completes, then IDLE with busy=0; 4 frames -> frame_count wraps to 0.
REQ-039 Assert reset at (2,1) -> next cycle coords (0,0), IDLE, irq_pending=0, frame_count unchanged from before reset only if not reset (SHALL read 0).
